// File: rtl/mod_scale_pow2_pkg.sv
// mod_scale_pkg: shared defaults, FSM state type and lane slicing helper
// for the modular power-of-two scaler.
package mod_scale_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int Q          = 12289;
  localparam int Q_HALF     = (Q + 1) / 2;
  localparam int K_WIDTH    = 4;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of a lane inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mod_step_lane.sv
// mod_step_lane: one combinational modular step on a single lane.
//   v    : operand, assumed already < Q
//   dir  : 0 = multiply by 2^-1 mod Q, 1 = multiply by 2 mod Q
//   res  : step result, < Q
module mod_step_lane #(
  parameter int DATA_WIDTH = mod_scale_pkg::DATA_WIDTH,
  parameter int Q          = mod_scale_pkg::Q
) (
  input  logic [DATA_WIDTH-1:0] v,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] res
);

  localparam logic [DATA_WIDTH:0] Q_W  = (DATA_WIDTH+1)'(Q);
  localparam logic [DATA_WIDTH:0] QH_W = (DATA_WIDTH+1)'((Q + 1) / 2);

  logic [DATA_WIDTH:0] v_ext;
  logic [DATA_WIDTH:0] half;
  logic [DATA_WIDTH:0] dbl;

  assign v_ext = {1'b0, v};

  // Odd v: (v + Q) / 2 == (v >> 1) + (Q + 1) / 2, which stays below Q.
  assign half = (v_ext >> 1) + (v[0] ? QH_W : '0);
  assign dbl  = v_ext << 1;

  always_comb begin
    res = DATA_WIDTH'(half);
    if (dir) begin
      if (dbl >= Q_W) res = DATA_WIDTH'(dbl - Q_W);
      else            res = DATA_WIDTH'(dbl);
    end
  end

endmodule

// File: rtl/mod_scale_pow2.sv
// mod_scale_pow2: multi-lane iterative scaler, x * 2^(+/-k) mod Q,
// one halving/doubling step per clock.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (in_dir, in_k, in_data)
//   out_valid/out_ready : result handshake (out_data)
//   busy                : high while a transaction is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one step per cycle on all lanes, cnt counts down to zero
// DONE  | result held on out_data until out_ready
module mod_scale_pow2 #(
  parameter int DATA_WIDTH = mod_scale_pkg::DATA_WIDTH,
  parameter int Q          = mod_scale_pkg::Q,
  parameter int LANES      = mod_scale_pkg::LANES,
  parameter int K_WIDTH    = mod_scale_pkg::K_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_dir,
  input  logic [K_WIDTH-1:0]          in_k,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        busy
);

  import mod_scale_pkg::*;

  localparam logic [DATA_WIDTH:0] Q_W = (DATA_WIDTH+1)'(Q);

  state_t state, state_next;
  logic   accept;

  logic [K_WIDTH-1:0]    cnt;
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] lane_q   [LANES];
  logic [DATA_WIDTH-1:0] lane_nxt [LANES];
  logic [DATA_WIDTH:0]   in_ext   [LANES];
  logic [DATA_WIDTH-1:0] in_red   [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign in_ext[g] = {1'b0, in_data[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH]};
    // Inputs are below 2*Q, so one conditional subtract fully reduces them.
    assign in_red[g] = (in_ext[g] >= Q_W) ? DATA_WIDTH'(in_ext[g] - Q_W)
                                          : DATA_WIDTH'(in_ext[g]);

    mod_step_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q          (Q)
    ) u_step (
      .v   (lane_q[g]),
      .dir (dir_q),
      .res (lane_nxt[g])
    );

    assign out_data[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH] = lane_q[g];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = (in_k != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt == K_WIDTH'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dir_q <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else if (accept) begin
      cnt   <= in_k;
      dir_q <= in_dir;
      for (int i = 0; i < LANES; i++) lane_q[i] <= in_red[i];
    end else if (state == RUN) begin
      cnt <= cnt - K_WIDTH'(1);
      for (int i = 0; i < LANES; i++) lane_q[i] <= lane_nxt[i];
    end
  end

endmodule

// File: tb/tb_mod_scale_pow2.sv
module tb_mod_scale_pow2;

  localparam int DW = 14;
  localparam int QM = 12289;
  localparam int NL = 4;
  localparam int KW = 4;
  localparam int LW = NL * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_dir = 1'b0;
  logic [KW-1:0] in_k = '0;
  logic [LW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mod_scale_pow2 #(.DATA_WIDTH(DW), .Q(QM), .LANES(NL), .K_WIDTH(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dir    (in_dir),
    .in_k      (in_k),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: x * 2^k mod Q or x * (2^-1)^k mod Q, where 2^-1 == (Q+1)/2.
  function automatic int model(input int x, input bit dir, input int k);
    longint r = longint'(x) % QM;
    longint m = dir ? 2 : (QM + 1) / 2;
    for (int i = 0; i < k; i++) r = (r * m) % QM;
    return int'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    logic [LW-1:0] d;
    d[0*DW +: DW] = DW'(l0);
    d[1*DW +: DW] = DW'(l1);
    d[2*DW +: DW] = DW'(l2);
    d[3*DW +: DW] = DW'(l3);
    return d;
  endfunction

  task automatic send(input bit dir, input int k, input logic [LW-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_dir   = dir;
    in_k     = KW'(k);
    in_data  = data;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic collect(output logic [LW-1:0] res, output int lat);
    wait_valid(lat);
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_lanes(input string tag, input bit dir, input int k,
                             input logic [LW-1:0] data, input logic [LW-1:0] res);
    for (int i = 0; i < NL; i++)
      check($sformatf("%s_lane%0d", tag, i), res[i*DW +: DW],
            model(int'(data[i*DW +: DW]), dir, k));
  endtask

  initial begin
    logic [LW-1:0] d, r, d0, db;
    int lat;

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_in_ready", in_ready, 1);
    check("idle_ready_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // halve k=1
    send(1'b0, 1, pack(1, 12288, 0, 2));
    collect(r, lat);
    check("h1_lat", lat, 2);
    check("h1_l0", r[0*DW +: DW], 6145);
    check("h1_l1", r[1*DW +: DW], 6144);
    check("h1_l2", r[2*DW +: DW], 0);
    check("h1_l3", r[3*DW +: DW], 1);

    // halve k=3 of 1 gives 8^-1 mod Q
    d = pack(77, 1, 12000, 3);
    send(1'b0, 3, d);
    collect(r, lat);
    check("h3_l1", r[1*DW +: DW], 10753);
    check_lanes("h3", 1'b0, 3, d, r);

    // round trip
    send(1'b0, 10, pack(5000, 5000, 5000, 5000));
    collect(r, lat);
    check("rt_half", r[0*DW +: DW], model(5000, 1'b0, 10));
    send(1'b1, 10, r);
    collect(r, lat);
    check("rt_back", r[0*DW +: DW], 5000);
    check("rt_back_l3", r[3*DW +: DW], 5000);

    // double k=1
    send(1'b1, 1, pack(12288, 6145, 0, 100));
    collect(r, lat);
    check("d1_l0", r[0*DW +: DW], 12287);
    check("d1_l1", r[1*DW +: DW], 1);
    check("d1_l3", r[3*DW +: DW], 200);

    // k=0 reduction only
    send(1'b1, 0, pack(16383, 12289, 12288, 5));
    collect(r, lat);
    check("k0_lat", lat, 1);
    check("k0_l0", r[0*DW +: DW], 4094);
    check("k0_l1", r[1*DW +: DW], 0);
    check("k0_l2", r[2*DW +: DW], 12288);

    // k=15 halve of 1
    d = pack(1, 2, 16000, 9999);
    send(1'b0, 15, d);
    collect(r, lat);
    check("k15_lat", lat, 16);
    check_lanes("k15", 1'b0, 15, d, r);

    // backpressure with a pending request
    d0 = pack(11, 22, 33, 44);
    send(1'b1, 2, d0);
    wait_valid(lat);
    r = out_data;
    check_lanes("bp_a", 1'b1, 2, d0, r);
    db = pack(400, 12345, 7, 8191);
    in_valid = 1'b1;
    in_dir   = 1'b0;
    in_k     = KW'(2);
    in_data  = db;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_stable%0d", c), out_data, r);
      check($sformatf("bp_in_ready%0d", c), in_ready, 0);
      check($sformatf("bp_out_valid%0d", c), out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_hs_in_ready", in_ready, 1);
    check("bp_after_hs_busy", busy, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(r, lat);
    check("bp_b_lat", lat, 3);
    check_lanes("bp_b", 1'b0, 2, db, r);

    // inputs wiggle during RUN
    d = pack(1234, 4321, 16383, 9);
    send(1'b1, 6, d);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_dir   = 1'($urandom);
      in_k     = KW'($urandom);
      in_data  = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    collect(r, lat);
    check_lanes("stab", 1'b1, 6, d, r);

    // async reset mid-RUN
    send(1'b0, 8, pack(100, 200, 300, 400));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_no_stale", out_valid, 0);
    d = pack(3, 12288, 16383, 6000);
    send(1'b1, 2, d);
    collect(r, lat);
    check("mrst_lat", lat, 3);
    check_lanes("mrst", 1'b1, 2, d, r);

    // random traffic
    for (int t = 0; t < 25; t++) begin
      bit dir;
      int k;
      dir = 1'($urandom);
      k   = int'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) d[i*DW +: DW] = DW'($urandom);
      send(dir, k, d);
      collect(r, lat);
      check($sformatf("rnd%0d_lat", t), lat, k + 1);
      check_lanes($sformatf("rnd%0d", t), dir, k, d, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mod_scale_pow2.md
Name: mod_scale_pow2

Overview:
Multi-lane iterative modular scaler that multiplies each of LANES operands by 2^-k or 2^+k modulo Q. It performs one halving or doubling step per clock.
- Halving by 2^-k is used for the INTT final n^-1 scaling.
- Doubling by 2^+k is used for the inverse correction.
It sits between the NTT butterfly array output and the coefficient memory write-back, behind a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 14, coefficient width; Q must satisfy 2^(DATA_WIDTH-1) < Q < 2^DATA_WIDTH.
- Q, 12289, odd modulus.
- LANES, 4, coefficients processed in parallel; all lanes share k and dir.
- K_WIDTH, 4, width of the step count; max k = 2^K_WIDTH-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_dir  in  1  0 = multiply by 2^-k (halve), 1 = multiply by 2^+k (double).
- in_k  in  K_WIDTH  number of steps.
- in_data  in  LANES*DATA_WIDTH  operands; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES*DATA_WIDTH  results, same lane packing as in_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1 after release, out_valid=0, busy=0.
  - out_data=0; lane registers, count and dir all cleared.
  - Reset mid-RUN or mid-DONE aborts the transaction; no partial result is emitted.
- FSM states IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid&&in_ready, latch dir and cnt=in_k.
  - Load each lane with reduce(x): x>=Q ? x-Q : x. This is always <Q given the Q bound.
  - Next state is RUN if in_k!=0, else DONE.
- RUN, each edge:
  - Every lane is replaced by step(lane, dir) and cnt decrements.
  - When cnt==1 before the edge, next state is DONE.
- step, halve (dir=0):
  - even v: v>>1.
  - odd v: (v>>1) + (Q+1)/2.
  - Result <Q; compute in DATA_WIDTH+1 bits.
- step, double (dir=1):
  - t = v<<1 in DATA_WIDTH+1 bits.
  - Result is t>=Q ? t-Q : t.
- Latency: out_valid rises k+1 cycles after the accepting cycle (k=0 gives 1 cycle, reduction only).
- DONE:
  - out_data is held stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready, next state is IDLE.
  - No same-cycle accept: in_ready is low in DONE, so throughput is one request per k+2 cycles minimum.
- Handshake rules:
  - in_data, in_k and in_dir are sampled only on the accepting edge.
  - Input changes during RUN have no effect.
  - in_valid may drop without acceptance; no protocol error.
- out_data is registered, driven directly from the lane registers and never combinational from inputs.
- Boundary cases:
  - k = max (15) runs exactly 15 steps.
  - Inputs in [Q, 2^DATA_WIDTH) are reduced, not flagged.
  - out_ready high while idle is ignored.

Decomposition:
- Package mod_scale_pkg holds:
  - DATA_WIDTH, Q, Q_HALF=(Q+1)/2, K_WIDTH defaults;
  - the state enum {IDLE,RUN,DONE};
  - the lane index/slice helper.
- One sub-module, mod_step_lane, is combinational. It takes v and dir and returns step(v,dir).
- The top instantiates LANES copies of mod_step_lane plus the FSM and counter.
- Load-time reduction is inline in the top.

Test Plan:
- Halve k=1: lanes {1,12288,0,2}, dir=0 -> {6145,6144,0,1}. out_valid exactly 2 cycles after accept.
- Halve k=3 on lane 1 -> 10753 (check 10753*8 mod 12289 = 1).
  - Round trip: 5000 halved k=10, then that output doubled k=10 -> 5000.
- Double k=1: 12288 -> 12287; 6145 -> 1.
  - k=0 with lane 16383 -> 4094 after 1 cycle.
  - k=15 halve of 1 -> 2^-15 mod Q; 16 cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_data stable, in_ready=0 throughout.
  - A new request pending on in_valid is accepted only in the cycle after the out handshake.
- Input stability: change in_data, in_k and in_dir every cycle during RUN -> result reflects the values latched at the accept edge only.
- Reset: assert rst_n=0 mid-RUN (k=8, after 3 steps) -> outputs go to reset values immediately (async).
  - After release, a fresh request k=2 completes correctly with no stale output_valid.
